fpadd_arbiter: RTL
==================

# fpadd_arbiter

Shares one single-precision FP adder datapath (unpack → alignment → add → normalize/round) between `NREQ` requesters. It accepts one operand pair at a time through valid/ready handshakes, picks the requester round-robin, drives and holds the operands on the adder, and samples the sum after a fixed latency. It returns the sum with the requester index on a backpressured response channel. It sits above the adder top level; the adder itself is external and purely combinational or fixed-latency.

## Interface
- `NREQ`, 2: number of requesters, 2..8.
- `ADD_LAT`, 1: clock edges from operand capture to sampling `add_sum`, 1..15.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in [NREQ]: per-requester operand pair valid.
- `req_a`, `req_b` in [NREQ][32]: IEEE-754 single operands per requester.
- `req_ready` out [NREQ]: one-hot grant/accept; at most one bit high.
- `add_a`, `add_b` out 32: registered operands to the adder.
- `add_start` out 1: one-cycle pulse in the first cycle new operands are presented.
- `add_sum` in 32: adder result.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_sum` out 32: captured sum.
- `rsp_id` out $clog2(NREQ): index of the requester that issued the operation.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP. Only one operation is outstanding at a time.
- IDLE: the arbiter forms a grant from `req_valid` and `rr_ptr`. The grant goes to the first valid index at or above `rr_ptr`, wrapping from NREQ-1 to 0. `req_ready[grant]`=1 combinationally; all other bits are 0.
  - Accept edge, `req_valid[g] && req_ready[g]`: latch `req_a[g]`/`req_b[g]` into `add_a`/`add_b`, latch g as id, set `rr_ptr` = (g+1) mod NREQ, load `lat_cnt` = ADD_LAT, go to WAIT.
  - No valid request: stay in IDLE; `rr_ptr` is unchanged.
- WAIT: `req_ready`=0. `add_start`=1 in the first WAIT cycle only. `lat_cnt` decrements each edge. On the edge where `lat_cnt`==1, capture `add_sum` into `rsp_sum` and go to RESP.
- RESP: `rsp_valid`=1. `rsp_sum` and `rsp_id` are stable until the handshake. On `rsp_valid && rsp_ready`, go to IDLE; no new accept happens in that same cycle.
- `add_a`/`add_b` hold their value from the accept edge until the next accept. They never change while in WAIT or RESP.
- Requesters must not drop `req_valid` or change operands before acceptance. `req_ready` may depend on `req_valid`; `req_valid` must not depend on `req_ready`.
- Operands pass through unmodified. The arbiter does no special-case handling of zero, denormal, inf or NaN inputs.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `rr_ptr`=0, `lat_cnt`=0, `add_a`=`add_b`=0, `add_start`=0, `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0, `busy`=0, `req_ready`=0 while reset is asserted.
- If reset asserts mid-operation, the in-flight operation is discarded and no response is produced. The first accept after release arbitrates from index 0.
- Latency: accept at edge E, `add_sum` sampled at edge E+ADD_LAT, `rsp_valid` high in the cycle after E+ADD_LAT.
- Minimum initiation interval is ADD_LAT+2 edges, with `rsp_ready` tied high.
- Backpressure: RESP holds indefinitely while `rsp_ready`=0.
- Fairness: under continuous requests from all NREQ requesters, each is served exactly once per NREQ operations.

## Structure
- Package `fpadd_pkg`:
  - `FP_WIDTH`=32.
  - `typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_t`.
  - `typedef logic [FP_WIDTH-1:0] fp32_t`.
- Sub-module `rr_picker`: combinational round-robin priority picker. Inputs are the request vector and pointer; outputs are the one-hot grant, the encoded index and `any`. The FSM, registers and latency counter stay in `fpadd_arbiter`.

## Test plan
- Single request, NREQ=2, ADD_LAT=1: requester 0 sends a=0x3F800000, b=0x40000000; adder model returns 0x40400000. Required: one cycle after the sample edge, `rsp_valid`=1, `rsp_sum`=0x40400000, `rsp_id`=0; `add_start` pulses exactly once.
- Both requesters valid continuously for 6 operations → `rsp_id` sequence 0,1,0,1,0,1; every accept is ≥3 edges apart.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_sum` and `rsp_id` constant; `req_ready`=0; `busy`=1. Release → exactly one handshake, then IDLE.
- ADD_LAT=3: adder model drives 0xDEADBEEF until the third edge after accept, then 0x41200000 → `rsp_sum`=0x41200000 only; `add_a`/`add_b` unchanged throughout WAIT.
- Reset asserted in the second WAIT cycle → all outputs 0 immediately; no `rsp_valid` afterwards. With requests from 0 and 1 after release, requester 0 is granted first.
- NREQ=3 wrap: with `rr_ptr`=2 and requests from 0 and 2 → grant 2, then 0, then 2.

Source files
------------

// File: rtl/fpadd_pkg.sv
// Shared types for the FP adder arbiter: operand word, FSM encoding, counter width.
package fpadd_pkg;

    localparam int unsigned FP_WIDTH = 32;
    localparam int unsigned LAT_W    = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_t;

    typedef logic [FP_WIDTH-1:0] fp32_t;

endpackage

// File: rtl/fpadd_arbiter_if.sv
// Request, adder and response signals of the FP adder arbiter.
interface fpadd_arbiter_if
    import fpadd_pkg::*;
#(
    parameter int unsigned NREQ = 2
);
    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    fp32_t           req_a [NREQ];
    fp32_t           req_b [NREQ];

    fp32_t           add_a;
    fp32_t           add_b;
    logic            add_start;
    fp32_t           add_sum;

    logic            rsp_valid;
    logic            rsp_ready;
    fp32_t           rsp_sum;
    logic [IW-1:0]   rsp_id;
    logic            busy;

    modport master (
        input  req_valid, req_a, req_b, add_sum, rsp_ready,
        output req_ready, add_a, add_b, add_start, rsp_valid, rsp_sum, rsp_id, busy
    );

    modport slave (
        output req_valid, req_a, req_b, add_sum, rsp_ready,
        input  req_ready, add_a, add_b, add_start, rsp_valid, rsp_sum, rsp_id, busy
    );

endinterface

// File: rtl/fpadd_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_picker #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [31:0]   w_pos;
    logic [IW-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        w_cand  = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            w_pos = 32'(i_ptr) + off;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            w_cand = IW'(w_pos);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP adder; one operation in flight at a time.
module fpadd_arbiter
    import fpadd_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned ADD_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    fpadd_arbiter_if.master bus
);

    localparam int unsigned IW = $clog2(NREQ);

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic [IW-1:0]    r_rr_ptr;
    logic [IW-1:0]    r_id;
    logic [LAT_W-1:0] r_lat_cnt;
    fp32_t            r_add_a;
    fp32_t            r_add_b;
    fp32_t            r_rsp_sum;

    logic [NREQ-1:0]  w_grant;
    logic [IW-1:0]    w_idx;
    logic             w_any;
    logic             w_accept;
    logic             w_last;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_accept = (r_state == IDLE) && w_any;
    assign w_last   = (r_lat_cnt == LAT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any)         w_next = WAIT;
            WAIT:    if (w_last)        w_next = RESP;
            RESP:    if (bus.rsp_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_id      <= '0;
            r_lat_cnt <= '0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_rsp_sum <= '0;
        end else begin
            if (w_accept) begin
                r_add_a   <= bus.req_a[w_idx];
                r_add_b   <= bus.req_b[w_idx];
                r_id      <= w_idx;
                r_rr_ptr  <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
                r_lat_cnt <= LAT_W'(ADD_LAT);
            end
            if (r_state == WAIT) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
                if (w_last) begin
                    r_rsp_sum <= bus.add_sum;
                end
            end
        end
    end

    // Grant is masked during reset because the picker still sees pointer 0 and live requests.
    always_comb begin
        bus.req_ready = ((r_state == IDLE) && !reset) ? w_grant : '0;
        bus.add_start = (r_state == WAIT) && (r_lat_cnt == LAT_W'(ADD_LAT));
        bus.rsp_valid = (r_state == RESP);
        bus.busy      = (r_state != IDLE);
    end

    assign bus.add_a   = r_add_a;
    assign bus.add_b   = r_add_b;
    assign bus.rsp_sum = r_rsp_sum;
    assign bus.rsp_id  = r_id;

endmodule
